// File: rtl/tag_control_pkg.sv
// Shared types and sizing for the command-tag allocator.
package tag_control_pkg;
   localparam int TAG_COUNT   = 256;
   localparam int TAG_WIDTH   = $clog2(TAG_COUNT);
   localparam int CU_ID_RANGE = 8;

   typedef logic [CU_ID_RANGE-1:0] cu_id_t;
   typedef logic [0:TAG_WIDTH-1]   tag_t;
   typedef logic [TAG_WIDTH:0]     count_t;

   localparam tag_t   INVALID_TAG = '0;
   localparam tag_t   LAST_TAG    = tag_t'(TAG_COUNT - 1);
   localparam count_t MAX_OUT     = count_t'(TAG_COUNT - 1);

   typedef enum logic [1:0] {
      TAG_RESET,
      TAG_INIT,
      TAG_RUN
   } tag_control_state_t;
endpackage

// File: rtl/tag_control_if.sv
// Tag request/grant and tag free/lookup bundle between CUs and tag_control.
interface tag_control_if;
   import tag_control_pkg::*;

   logic   tag_request_valid;
   cu_id_t tag_request_cu_id;
   logic   tag_response_valid;
   tag_t   tag_response_tag;
   logic   tag_free_valid;
   tag_t   tag_free_tag;
   logic   tag_free_cu_id_valid;
   cu_id_t tag_free_cu_id;
   logic   tags_available;
   count_t tags_outstanding;
   logic   tag_error;

   modport master (
      output tag_request_valid, tag_request_cu_id,
      output tag_free_valid, tag_free_tag,
      input  tag_response_valid, tag_response_tag,
      input  tag_free_cu_id_valid, tag_free_cu_id,
      input  tags_available, tags_outstanding, tag_error
   );

   modport slave (
      input  tag_request_valid, tag_request_cu_id,
      input  tag_free_valid, tag_free_tag,
      output tag_response_valid, tag_response_tag,
      output tag_free_cu_id_valid, tag_free_cu_id,
      output tags_available, tags_outstanding, tag_error
   );
endinterface

// File: rtl/tag_control_free_fifo.sv
// Synchronous FIFO (power-of-two depth) with occupancy count; storage is not reset.
module tag_free_fifo
   import tag_control_pkg::*;
#(
   parameter int DEPTH = TAG_COUNT,
   parameter int WIDTH = TAG_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i && (cnt_q != (AW+1)'(DEPTH));
   assign do_pop  = pop_i && (cnt_q != '0);

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   // Pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   assign data_o  = mem_q[rd_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
endmodule

// File: rtl/tag_control.sv
// Command-tag allocator: free-list FIFO plus tag-to-CU table.
// Optional TAG_CONTROL_ERROR_CHECK_EN adds an allocated bitmap and sticky tag_error.
module tag_control
   import tag_control_pkg::*;
(
   input logic          clock,
   input logic          rstn,
   input logic          enabled,
   tag_control_if.slave bus
);
   tag_control_state_t state_q;
   tag_t               init_tag_q;
   logic               resp_valid_q;
   tag_t               resp_tag_q;
   logic               free_valid_q;
   cu_id_t             free_cu_q;
   logic               avail_q;
   count_t             out_q;
   cu_id_t             table_q [TAG_COUNT];

   logic   run;
   logic   init;
   logic   grant;
   logic   free_ok;
   logic   push;
   tag_t   push_tag;
   tag_t   head;
   logic   fifo_empty;
   count_t fifo_cnt;
   count_t cnt_next;

   assign run   = (state_q == TAG_RUN);
   assign init  = (state_q == TAG_INIT);
   assign grant = run && bus.tag_request_valid && !fifo_empty;

`ifdef TAG_CONTROL_ERROR_CHECK_EN
   logic [TAG_COUNT-1:0] alloc_q;
   logic                 err_q;
   logic                 free_bad;

   assign free_ok  = run && bus.tag_free_valid && alloc_q[bus.tag_free_tag];
   assign free_bad = run && bus.tag_free_valid && !alloc_q[bus.tag_free_tag];

   // Tag 0 is never granted, so its bit stays clear and its free is flagged.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         alloc_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (grant)    alloc_q[head] <= 1'b1;
         if (free_ok)  alloc_q[bus.tag_free_tag] <= 1'b0;
         if (free_bad) err_q <= 1'b1;
      end
   end

   assign bus.tag_error = err_q;
`else
   assign free_ok = run && bus.tag_free_valid &&
                    (bus.tag_free_tag != INVALID_TAG);
   assign bus.tag_error = 1'b0;
`endif

   // Freed tags go to the tail, never bypassed to a same-cycle request.
   assign push     = init || free_ok;
   assign push_tag = init ? init_tag_q : bus.tag_free_tag;
   assign cnt_next = fifo_cnt + count_t'(push) - count_t'(grant);

   tag_free_fifo #(
      .DEPTH (TAG_COUNT),
      .WIDTH (TAG_WIDTH)
   ) u_fifo (
      .clk     (clock),
      .rst_n   (rstn),
      .push_i  (push),
      .data_i  (push_tag),
      .pop_i   (grant),
      .data_o  (head),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_ff @(posedge clock) begin
      if (grant) table_q[head] <= bus.tag_request_cu_id;
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q      <= TAG_RESET;
         init_tag_q   <= tag_t'(1);
         resp_valid_q <= 1'b0;
         resp_tag_q   <= '0;
         free_valid_q <= 1'b0;
         free_cu_q    <= '0;
         avail_q      <= 1'b0;
         out_q        <= '0;
      end else begin
         resp_valid_q <= grant;
         if (grant) resp_tag_q <= head;
         free_valid_q <= free_ok;
         if (free_ok) free_cu_q <= table_q[bus.tag_free_tag];
         if (grant && !free_ok && out_q != MAX_OUT)
            out_q <= out_q + 1'b1;
         else if (free_ok && !grant && out_q != '0)
            out_q <= out_q - 1'b1;
         unique case (state_q)
            TAG_RESET: begin
               if (enabled) state_q <= TAG_INIT;
            end
            TAG_INIT: begin
               init_tag_q <= init_tag_q + 1'b1;
               if (init_tag_q == LAST_TAG) begin
                  state_q <= TAG_RUN;
                  avail_q <= 1'b1;
               end
            end
            TAG_RUN: begin
               avail_q <= (cnt_next != '0);
            end
            default: state_q <= TAG_RESET;
         endcase
      end
   end

   assign bus.tag_response_valid   = resp_valid_q;
   assign bus.tag_response_tag     = resp_tag_q;
   assign bus.tag_free_cu_id_valid = free_valid_q;
   assign bus.tag_free_cu_id       = free_cu_q;
   assign bus.tags_available       = avail_q;
   assign bus.tags_outstanding     = out_q;
endmodule

// File: tb/tb_tag_control.sv
// Randomised bench for tag_control against a queue-based free-list model.
module tb_tag_control;
   logic clk = 1'b0;
   logic rstn;
   logic enabled;

   tag_control_if bus ();

   tag_control dut (
      .clock   (clk),
      .rstn    (rstn),
      .enabled (enabled),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   int               fq[$];
   logic [7:0]       outs[$];
   byte unsigned     m_owner [256];
   bit               m_alloc [256];
   bit               m_run;
   bit               m_err;
   int               m_out;
   bit               e_rv, e_fv, e_avail;
   logic [7:0]       e_tag, e_cu;

   task automatic model_reset();
      fq.delete();
      outs.delete();
      for (int i = 0; i < 256; i++) m_alloc[i] = 1'b0;
      m_run = 1'b0;
      m_err = 1'b0;
      m_out = 0;
   endtask

   task automatic model_init();
      model_reset();
      for (int i = 1; i < 256; i++) fq.push_back(i);
      m_run = 1'b1;
   endtask

   task automatic step(input bit req, input byte unsigned cu,
                       input bit fv, input byte unsigned ft);
      bit g, f, bad;
      int t;
      g = m_run && req && (fq.size() > 0);
      bad = 1'b0;
`ifdef TAG_CONTROL_ERROR_CHECK_EN
      f = m_run && fv && m_alloc[ft];
      bad = m_run && fv && !m_alloc[ft];
`else
      f = m_run && fv && (ft != 0);
`endif
      e_rv = g;
      e_fv = f;
      if (g) begin
         t = fq.pop_front();
         e_tag = t[7:0];
         m_owner[t] = cu;
         m_alloc[t] = 1'b1;
         outs.push_back(t[7:0]);
      end
      if (f) begin
         fq.push_back(int'(ft));
         e_cu = m_owner[ft];
         m_alloc[ft] = 1'b0;
         for (int k = 0; k < outs.size(); k++)
            if (outs[k] == ft) begin
               outs.delete(k);
               break;
            end
      end
      if (bad) m_err = 1'b1;
      if (g && !f && m_out < 255) m_out++;
      else if (f && !g && m_out > 0) m_out--;
      e_avail = m_run && (fq.size() > 0);
      bus.tag_request_valid = req;
      bus.tag_request_cu_id = cu;
      bus.tag_free_valid    = fv;
      bus.tag_free_tag      = ft;
      @(posedge clk);
      @(negedge clk);
      bus.tag_request_valid = 1'b0;
      bus.tag_free_valid    = 1'b0;
   endtask

   task automatic reinit();
      int n;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      rstn = 1'b1;
      enabled = 1'b1;
      n = 0;
      while (n < 400 && bus.tags_available !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (bus.tags_available !== 1'b1) begin
         n_fail++;
         $display("FAIL reinit_timeout: tags_available=%b required 1", bus.tags_available);
      end
      model_init();
   endtask

   task automatic test_reset();
      int n;
      bit found;
      rstn = 1'b0;
      enabled = 1'b0;
      bus.tag_request_valid = 1'b0;
      bus.tag_request_cu_id = '0;
      bus.tag_free_valid = 1'b0;
      bus.tag_free_tag = '0;
      model_reset();
      repeat (3) @(negedge clk);
      n_chk++;
      if (bus.tag_response_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_resp_valid: got %b required 0", bus.tag_response_valid);
      end
      n_chk++;
      if (bus.tag_response_tag !== 8'h00) begin
         n_fail++; $display("FAIL rst_resp_tag: got %h required 00", bus.tag_response_tag);
      end
      n_chk++;
      if (bus.tag_free_cu_id_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_free_valid: got %b required 0", bus.tag_free_cu_id_valid);
      end
      n_chk++;
      if (bus.tag_free_cu_id !== 8'h00) begin
         n_fail++; $display("FAIL rst_free_cu: got %h required 00", bus.tag_free_cu_id);
      end
      n_chk++;
      if (bus.tags_available !== 1'b0) begin
         n_fail++; $display("FAIL rst_avail: got %b required 0", bus.tags_available);
      end
      n_chk++;
      if (bus.tags_outstanding !== 9'd0) begin
         n_fail++; $display("FAIL rst_outstanding: got %0d required 0", bus.tags_outstanding);
      end
      n_chk++;
      if (bus.tag_error !== 1'b0) begin
         n_fail++; $display("FAIL rst_error: got %b required 0", bus.tag_error);
      end
      rstn = 1'b1;
      enabled = 1'b1;
      repeat (100) @(negedge clk);
      rstn = 1'b0;
      #1;
      n_chk++;
      if (bus.tags_available !== 1'b0) begin
         n_fail++; $display("FAIL midinit_avail: got %b required 0", bus.tags_available);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      n = 0;
      found = 1'b0;
      while (n < 400 && !found) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (bus.tags_available === 1'b1) found = 1'b1;
      end
      n_chk++;
      if (!found || n != 255) begin
         n_fail++; $display("FAIL init_latency: got %0d cycles (found=%0b) required 255", n, found);
      end
      model_init();
   endtask

   task automatic test_alloc_free();
      step(1'b1, 8'h05, 1'b0, 8'h00);
      n_chk++;
      if (bus.tag_response_valid !== 1'b1 || bus.tag_response_tag !== 8'd1) begin
         n_fail++; $display("FAIL grant1: valid=%b tag=%0d required 1/1",
                            bus.tag_response_valid, bus.tag_response_tag);
      end
      step(1'b1, 8'h07, 1'b0, 8'h00);
      n_chk++;
      if (bus.tag_response_valid !== 1'b1 || bus.tag_response_tag !== 8'd2) begin
         n_fail++; $display("FAIL grant2: valid=%b tag=%0d required 1/2",
                            bus.tag_response_valid, bus.tag_response_tag);
      end
      n_chk++;
      if (bus.tags_outstanding !== 9'd2) begin
         n_fail++; $display("FAIL outstanding2: got %0d required 2", bus.tags_outstanding);
      end
      step(1'b0, 8'h00, 1'b1, 8'd2);
      n_chk++;
      if (bus.tag_free_cu_id_valid !== 1'b1 || bus.tag_free_cu_id !== 8'h07) begin
         n_fail++; $display("FAIL free2_lookup: valid=%b cu=%h required 1/07",
                            bus.tag_free_cu_id_valid, bus.tag_free_cu_id);
      end
      n_chk++;
      if (bus.tags_outstanding !== 9'd1) begin
         n_fail++; $display("FAIL outstanding1: got %0d required 1", bus.tags_outstanding);
      end
   endtask

   task automatic test_exhaust();
      int guard;
      guard = 0;
      while (fq.size() > 0 && guard < 300) begin
         step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'h00);
         guard++;
         n_chk++;
         if (bus.tag_response_valid !== 1'b1 || bus.tag_response_tag !== e_tag) begin
            n_fail++; $display("FAIL exhaust_grant: valid=%b tag=%0d required 1/%0d",
                               bus.tag_response_valid, bus.tag_response_tag, e_tag);
         end
      end
      n_chk++;
      if (bus.tags_available !== 1'b0 || bus.tags_outstanding !== 9'd255) begin
         n_fail++; $display("FAIL exhaust_state: avail=%b out=%0d required 0/255",
                            bus.tags_available, bus.tags_outstanding);
      end
      step(1'b1, 8'h11, 1'b0, 8'h00);
      n_chk++;
      if (bus.tag_response_valid !== 1'b0) begin
         n_fail++; $display("FAIL empty_drop: valid=%b required 0", bus.tag_response_valid);
      end
      step(1'b1, 8'h09, 1'b1, 8'd10);
      n_chk++;
      if (bus.tag_response_valid !== 1'b0 || bus.tag_free_cu_id_valid !== 1'b1 ||
          bus.tags_available !== 1'b1) begin
         n_fail++; $display("FAIL no_bypass: resp=%b free=%b avail=%b required 0/1/1",
                            bus.tag_response_valid, bus.tag_free_cu_id_valid,
                            bus.tags_available);
      end
      step(1'b1, 8'h09, 1'b0, 8'h00);
      n_chk++;
      if (bus.tag_response_valid !== 1'b1 || bus.tag_response_tag !== 8'd10 ||
          bus.tags_outstanding !== 9'd255) begin
         n_fail++; $display("FAIL regrant10: valid=%b tag=%0d out=%0d required 1/10/255",
                            bus.tag_response_valid, bus.tag_response_tag,
                            bus.tags_outstanding);
      end
   endtask

   task automatic test_back_to_back();
      int hits;
      while (m_out > 100)
         step(1'b0, 8'h00, 1'b1, outs[$urandom_range(0, outs.size() - 1)]);
      for (int c = 0; c < 1000; c++) begin
         step(1'b1, 8'($urandom_range(0, 255)), 1'b1,
              outs[$urandom_range(0, outs.size() - 1)]);
         n_chk++;
         if (bus.tag_response_valid !== 1'b1 || bus.tag_response_tag !== e_tag) begin
            n_fail++; $display("FAIL b2b_grant: valid=%b tag=%0d required 1/%0d",
                               bus.tag_response_valid, bus.tag_response_tag, e_tag);
         end
         n_chk++;
         if (bus.tag_free_cu_id_valid !== 1'b1 || bus.tag_free_cu_id !== e_cu) begin
            n_fail++; $display("FAIL b2b_lookup: valid=%b cu=%h required 1/%h",
                               bus.tag_free_cu_id_valid, bus.tag_free_cu_id, e_cu);
         end
         n_chk++;
         if (bus.tags_outstanding !== 9'd100) begin
            n_fail++; $display("FAIL b2b_outstanding: got %0d required 100",
                               bus.tags_outstanding);
         end
         hits = 0;
         foreach (outs[k]) if (outs[k] == bus.tag_response_tag) hits++;
         n_chk++;
         if (hits != 1) begin
            n_fail++; $display("FAIL b2b_unique: tag %0d held %0d times required 1",
                               bus.tag_response_tag, hits);
         end
      end
   endtask

   task automatic test_random();
      bit req, fv;
      logic [7:0] ft;
      for (int c = 0; c < 600; c++) begin
         enabled = 1'($urandom_range(0, 1));
         req = ($urandom_range(0, 3) != 0);
         fv = (outs.size() > 0) && ($urandom_range(0, 2) != 0);
         ft = fv ? outs[$urandom_range(0, outs.size() - 1)] : 8'h00;
         if (fv && $urandom_range(0, 15) == 0) ft = 8'h00;
         step(req, 8'($urandom_range(0, 255)), fv, ft);
         n_chk++;
         if (bus.tag_response_valid !== e_rv ||
             (e_rv && bus.tag_response_tag !== e_tag)) begin
            n_fail++; $display("FAIL rnd_grant: valid=%b tag=%0d required %b/%0d",
                               bus.tag_response_valid, bus.tag_response_tag, e_rv, e_tag);
         end
         n_chk++;
         if (bus.tag_free_cu_id_valid !== e_fv ||
             (e_fv && bus.tag_free_cu_id !== e_cu)) begin
            n_fail++; $display("FAIL rnd_lookup: valid=%b cu=%h required %b/%h",
                               bus.tag_free_cu_id_valid, bus.tag_free_cu_id, e_fv, e_cu);
         end
         n_chk++;
         if (bus.tags_outstanding !== 9'(m_out) || bus.tags_available !== e_avail) begin
            n_fail++; $display("FAIL rnd_state: out=%0d avail=%b required %0d/%b",
                               bus.tags_outstanding, bus.tags_available, m_out, e_avail);
         end
         n_chk++;
         if (bus.tag_error !== m_err) begin
            n_fail++; $display("FAIL rnd_error: got %b required %b", bus.tag_error, m_err);
         end
      end
      enabled = 1'b1;
   endtask

   task automatic test_error();
      bit exp_err;
`ifdef TAG_CONTROL_ERROR_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      reinit();
      step(1'b0, 8'h00, 1'b1, 8'd0);
      n_chk++;
      if (bus.tag_free_cu_id_valid !== 1'b0 || bus.tag_error !== exp_err) begin
         n_fail++; $display("FAIL free_tag0: valid=%b err=%b required 0/%b",
                            bus.tag_free_cu_id_valid, bus.tag_error, exp_err);
      end
      step(1'b0, 8'h00, 1'b1, 8'd50);
      n_chk++;
      if (bus.tag_free_cu_id_valid !== !exp_err || bus.tag_error !== exp_err) begin
         n_fail++; $display("FAIL free_unalloc50: valid=%b err=%b required %b/%b",
                            bus.tag_free_cu_id_valid, bus.tag_error, !exp_err, exp_err);
      end
      n_chk++;
      if (bus.tags_outstanding !== 9'd0) begin
         n_fail++; $display("FAIL err_outstanding: got %0d required 0", bus.tags_outstanding);
      end
      step(1'b0, 8'h00, 1'b0, 8'h00);
      step(1'b0, 8'h00, 1'b0, 8'h00);
      n_chk++;
      if (bus.tag_error !== exp_err) begin
         n_fail++; $display("FAIL err_sticky: got %b required %b", bus.tag_error, exp_err);
      end
   endtask

   initial begin
      test_reset();
      test_alloc_free();
      test_exhaust();
      test_back_to_back();
      test_random();
      test_error();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/tag_control.md
Name: tag_control

Overview:
- Command-tag allocator sitting directly upstream of the AFU command buffers (read/write/restart/WED).
- Hands a unique 8-bit command tag to each issuing compute unit and records which CU ID owns it.
- Looks up the owner CU ID when the response for that tag returns, then recycles the tag.
- Built on a free-list FIFO plus a tag-to-CU_ID table. Tag 0 is the invalid tag and is never issued.

Parameters:
- TAG_COUNT, 256: total tag space; usable tags 1..TAG_COUNT-1.
- TAG_WIDTH, 8: $clog2(TAG_COUNT).
- CU_ID_RANGE, 8: width of cu_id_t.

Ports:
- clock  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- enabled  in  1  level; initialisation starts on the first cycle this is high after reset.
- tag_request_valid  in  1  CU requests a tag this cycle.
- tag_request_cu_id  in  CU_ID_RANGE  ID of the requesting CU.
- tag_response_valid  out  1  grant pulse.
- tag_response_tag  out  TAG_WIDTH  granted tag.
- tag_free_valid  in  1  a response for tag_free_tag has arrived.
- tag_free_tag  in  TAG_WIDTH  tag being returned.
- tag_free_cu_id_valid  out  1  lookup result valid.
- tag_free_cu_id  out  CU_ID_RANGE  owner of the returned tag.
- tags_available  out  1  free list non-empty and init done.
- tags_outstanding  out  TAG_WIDTH+1  count of allocated tags.
- tag_error  out  1  sticky error (see Optional Feature).

Behaviour:
- Reset (async, rstn=0):
  - FSM goes to RESET.
  - Outputs: all valids 0, tags_available 0, tags_outstanding 0, tag_error 0, tag/cu_id outputs 0.
  - FIFO pointers cleared. Table contents are don't-care.
- FSM: RESET -> INIT -> RUN.
  - RESET -> INIT when enabled=1.
  - INIT pushes tags 1..TAG_COUNT-1 into the free FIFO, one per cycle (255 cycles).
  - INIT -> RUN after the last push.
  - RUN is held until reset. Deasserting enabled has no effect.
- Requests and frees are ignored outside RUN.
- Allocate (RUN):
  - Condition: tag_request_valid=1 and FIFO not empty.
  - Pop the head, write table[tag] <= tag_request_cu_id.
  - Next cycle: tag_response_valid=1, tag_response_tag=popped tag.
  - Latency 1 cycle. One grant per cycle maximum.
- Request while the FIFO is empty:
  - Dropped, no response. The requester must hold or retry; gate requests on tags_available.
- Free (RUN):
  - tag_free_valid=1: read table[tag_free_tag] and push the tag onto the FIFO.
  - Next cycle: tag_free_cu_id_valid=1, tag_free_cu_id=owner.
  - Latency 1 cycle.
- Simultaneous allocate and free:
  - Both are performed. tags_outstanding is unchanged.
  - A freed tag is never bypassed to a same-cycle request. If the FIFO was empty, the request is dropped; the freed tag becomes available next cycle.
- tags_outstanding:
  - +1 per grant, -1 per accepted free, saturating at 0 and TAG_COUNT-1.
- tags_available: registered, equals (RUN and FIFO count after this cycle's push/pop > 0).
- FIFO depth is TAG_COUNT, so it can never overflow with legal frees.
- Pointers wrap modulo TAG_COUNT.
- A free of tag 0 is ignored: no push, no lookup output.

Optional Feature:
- Macro: TAG_CONTROL_ERROR_CHECK_EN.
- When defined:
  - Keep a TAG_COUNT-bit allocated bitmap: set on grant, cleared on free.
  - A free of an unallocated tag, or of tag 0, sets tag_error (sticky until reset). The free is ignored: no push, no lookup, no count change.
- When undefined:
  - No bitmap; tag_error is tied to 0.
  - Frees of tags 1..255 are trusted and always pushed.

Decomposition:
- Shared globals package provides TAG_COUNT, INVALID_TAG, CU_ID_RANGE and cu_id_t.
- Add to the package:
  - typedef logic [0:TAG_WIDTH-1] tag_t;
  - enum tag_control_state_t {TAG_RESET, TAG_INIT, TAG_RUN}.
- One sub-module: tag_free_fifo.
  - Synchronous FIFO, depth TAG_COUNT, width TAG_WIDTH.
  - Ports: push, pop, data, empty, count.
  - Reused for other buffers.

Test Plan:
- Reset mid-INIT at cycle 100, release, enabled=1 -> tags_available goes to 1 exactly 255 cycles after INIT entry; no stale tags.
- After init, request with cu_id=8'h05 -> next cycle tag_response_tag=1; then cu_id=8'h07 -> tag=2; tags_outstanding=2.
- Free tag 2 -> next cycle tag_free_cu_id=8'h07, valid=1; tags_outstanding=1.
- Allocate 255 times -> tags_available=0. A 256th request gets no response. Free tag 10 and request in the same cycle -> that request is dropped; the next-cycle request is granted tag 10.
- Continuous alloc+free every cycle for 1000 cycles -> tags_outstanding constant; all granted tags unique among outstanding; FIFO wrap exercised.
- With TAG_CONTROL_ERROR_CHECK_EN: free unallocated tag 50 -> tag_error=1 sticky, count unchanged. Without the macro: tag_error stays 0.
